tdm_demux16: RTL and testbench

Sequential 1-to-16 time-division demultiplexer and deserializer. It is the receive end of the 16:1 select-mux channel: one serial bit arrives per slot, selected channel 0..15 in order. The block steers each bit into its channel slot with an internal auto-incrementing channel counter, then presents the reassembled 16-bit word with a one-cycle valid strobe. It sits after the serial link and feeds 16 parallel channel consumers.

---
 rtl/tdm_demux16.sv | 77 +++++++
 tb/tb_tdm_demux16.sv | 115 +++++++++++
 2 files changed

// File: rtl/tdm_demux16.sv
// tdm_demux16: 1-to-16 TDM demultiplexer/deserializer with a framed output strobe.
// Define TDM_PARITY_EN to add a 17th even-parity slot and enable parity_err.
module tdm_demux16 #(
    parameter int N_CH = 16,
    parameter int SEL_W = 4,
`ifdef TDM_PARITY_EN
    localparam int IDX_W = SEL_W + 1,
    localparam int LAST = N_CH
`else
    localparam int IDX_W = SEL_W,
    localparam int LAST = N_CH - 1
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [IDX_W-1:0] ch_idx,
    output logic [N_CH-1:0]  dout,
    output logic             dout_valid,
    output logic             frame_err,
    output logic             parity_err
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] idx_nx;
    logic [N_CH-1:0] shadow, shadow_nx, dout_nx;
    logic last, perr_nx, ferr_nx;
    // sof takes priority over completion: a sof on the last slot restarts the frame
    assign last = din_valid && !sof && ch_idx == IDX_W'(LAST);
    always_comb begin
        state_nx = state;
        idx_nx = ch_idx;
        shadow_nx = shadow;
        dout_nx = dout;
        perr_nx = 1'b0;
        ferr_nx = frame_err | (sof && state == COLLECT);
        if (sof) begin
            shadow_nx = {{(N_CH-1){1'b0}}, din & din_valid};
            idx_nx = din_valid ? IDX_W'(1) : '0;
            state_nx = din_valid ? COLLECT : IDLE;
        end else if (last) begin
            idx_nx = '0;
            state_nx = IDLE;
`ifdef TDM_PARITY_EN
            dout_nx = shadow;
            perr_nx = ^shadow ^ din;
`else
            dout_nx = {din, shadow[N_CH-2:0]};
`endif
        end else if (din_valid) begin
            shadow_nx[ch_idx[SEL_W-1:0]] = din;
            idx_nx = ch_idx + 1'b1;
            state_nx = COLLECT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch_idx <= '0;
            shadow <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
            frame_err <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state <= state_nx;
            ch_idx <= idx_nx;
            shadow <= shadow_nx;
            dout <= dout_nx;
            dout_valid <= last;
            frame_err <= ferr_nx;
            parity_err <= perr_nx;
        end
    end
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: randomized and directed bench against a queue-based frame model.
module tb_tdm_demux16;
`ifdef TDM_PARITY_EN
    localparam int SLOTS = 17;
    localparam int IW = 5;
`else
    localparam int SLOTS = 16;
    localparam int IW = 4;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic sof = 1'b0;
    logic [IW-1:0] ch_idx;
    logic [15:0] dout;
    logic dout_valid, frame_err, parity_err;
    int checks = 0;
    int errors = 0;
    bit q[$];
    logic [15:0] m_dout = '0;
    logic m_valid = 1'b0;
    logic m_ferr = 1'b0;
    logic m_perr = 1'b0;

    tdm_demux16 dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .ch_idx(ch_idx), .dout(dout), .dout_valid(dout_valid),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic v, input logic d, input logic s, input logic r);
        logic [15:0] w;
        din = d;
        din_valid = v;
        sof = s;
        rst = r;
        @(posedge clk);
        m_valid = 1'b0;
        m_perr = 1'b0;
        if (r) begin
            q.delete();
            m_dout = '0;
            m_ferr = 1'b0;
        end else begin
            if (s) begin
                if (q.size() != 0) m_ferr = 1'b1;
                q.delete();
            end
            if (v) begin
                q.push_back(d);
                if (q.size() == SLOTS) begin
                    for (int i = 0; i < 16; i++) w[i] = q[i];
                    m_dout = w;
                    m_valid = 1'b1;
                    if (SLOTS == 17) m_perr = ^w ^ q[SLOTS-1];
                    q.delete();
                end
            end
        end
        #1;
        check("ch_idx", 32'(ch_idx), 32'(q.size()));
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic send(input logic [15:0] w, input bit gaps, input bit pflip);
        for (int i = 0; i < SLOTS; i++) begin
            step(1'b1, i < 16 ? w[i % 16] : (^w) ^ pflip, 1'b0, 1'b0);
            if (gaps) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] w;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'hAAAA, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'hAAAA, 1'b1, 1'b0);
        send(16'h00FF, 1'b0, 1'b0);
        send(16'h8001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        w = 16'h1234;
        step(1'b1, w[0], 1'b1, 1'b0);
        for (int i = 1; i < SLOTS; i++) step(1'b1, i < 16 ? w[i % 16] : ^w, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send(16'h5A5A, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 99) < 75, 1'($urandom), $urandom_range(0, 99) < 2,
                 $urandom_range(0, 999) < 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
